// File: rtl/div_8by4_seq.sv
// Sequential restoring divider: a 2*BITS-bit dividend divided by a BITS-bit divisor,
// one quotient bit per clock, with a start/busy/done handshake.
module div_8by4_seq #(
    parameter int unsigned BITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [2*BITS-1:0]   dividend,
    input  logic [BITS-1:0]     divisor,
    output logic                busy,
    output logic                done,
    output logic [2*BITS-1:0]   quotient,
    output logic [BITS-1:0]     remainder,
    output logic                div_by_zero
);

    localparam int unsigned   CW   = $clog2(2 * BITS) + 1;
    localparam logic [CW-1:0] LAST = CW'(2 * BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [2*BITS-1:0]   r_q_sh;
    logic [BITS-1:0]     r_rem;
    logic [BITS-1:0]     r_dvs;
    logic [CW-1:0]       r_cnt;

    logic                w_accept;
    logic                w_zero;
    logic                w_last;
    logic [BITS:0]       w_t;
    logic                w_ge;
    logic [BITS-1:0]     w_r_next;
    logic [2*BITS-1:0]   w_q_next;

    assign w_accept = start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_zero   = (divisor == '0);
    assign w_last   = (r_cnt == LAST);

    // The partial remainder always stays below the divisor, so BITS bits hold it and
    // the subtraction can be done modulo 2^BITS without losing the result.
    assign w_t      = {r_rem, r_q_sh[2*BITS-1]};
    assign w_ge     = (w_t >= {1'b0, r_dvs});
    assign w_r_next = w_ge ? (w_t[BITS-1:0] - r_dvs) : w_t[BITS-1:0];
    assign w_q_next = {r_q_sh[2*BITS-2:0], w_ge};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = w_zero ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    w_next = w_zero ? S_DONE : S_RUN;
                end else begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == S_RUN);
        done = (r_state == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q_sh      <= '0;
            r_rem       <= '0;
            r_dvs       <= '0;
            r_cnt       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (w_accept) begin
            if (w_zero) begin
                quotient    <= '1;
                remainder   <= '0;
                div_by_zero <= 1'b1;
            end else begin
                r_q_sh <= dividend;
                r_rem  <= '0;
                r_dvs  <= divisor;
                r_cnt  <= '0;
            end
        end else if (r_state == S_RUN) begin
            r_q_sh <= w_q_next;
            r_rem  <= w_r_next;
            r_cnt  <= r_cnt + CW'(1);
            if (w_last) begin
                quotient    <= w_q_next;
                remainder   <= w_r_next;
                div_by_zero <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_div_8by4_seq.sv
// Bench for div_8by4_seq: expected results are queued on each accepted start and
// checked when done pulses; includes reset, div-by-zero, back-to-back and a full sweep.
module tb_div_8by4_seq;

    localparam int unsigned BITS = 4;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                start;
    logic [2*BITS-1:0]   dividend;
    logic [BITS-1:0]     divisor;
    logic                busy;
    logic                done;
    logic [2*BITS-1:0]   quotient;
    logic [BITS-1:0]     remainder;
    logic                div_by_zero;

    typedef struct packed {
        logic [7:0] q;
        logic [3:0] r;
        logic       z;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    div_8by4_seq #(.BITS(BITS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    function automatic exp_t model(input int dd, input int dv);
        exp_t e;
        if (dv == 0) begin
            e.q = 8'hFF;
            e.r = 4'h0;
            e.z = 1'b1;
        end else begin
            e.q = 8'(dd / dv);
            e.r = 4'(dd % dv);
            e.z = 1'b0;
        end
        return e;
    endfunction

    // Called at a falling edge; the request is taken on the following rising edge.
    task automatic drive_start(input int dd, input int dv);
        dividend = 8'(dd);
        divisor  = 4'(dv);
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    // lat counts falling edges from the one just after the accepting edge up to done.
    task automatic wait_done(output int lat, output bit busy_seen, output bit overlap,
                             output bit timeout);
        lat = 0; busy_seen = 0; overlap = 0; timeout = 0;
        forever begin
            if (busy === 1'b1 && done === 1'b1) overlap = 1;
            if (busy === 1'b1) busy_seen = 1;
            if (done === 1'b1) break;
            if (lat >= 40) begin
                timeout = 1;
                break;
            end
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        int lat; bit bs, ov, to;
        repeat (2) @(negedge clk);
        total++;
        if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
            bad++;
            $display("FAIL reset_state got=%b want=0", {busy, done, quotient, remainder, div_by_zero});
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        drive_start(13, 0);
        wait_done(lat, bs, ov, to);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
            bad++;
            $display("FAIL reset_async got=%b want=0", {busy, done, quotient, remainder, div_by_zero});
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({busy, done} !== 2'b00) begin
            bad++;
            $display("FAIL reset_idle busy_done got=%b want=00", {busy, done});
        end
    endtask

    task automatic test_basic();
        int lat; bit bs, ov, to; exp_t e;
        sb.push_back(model(225, 15));
        drive_start(225, 15);
        wait_done(lat, bs, ov, to);
        total++;
        if (to || lat !== 8) begin
            bad++;
            $display("FAIL basic_latency got=%0d want=8 timeout=%0d", lat, to);
        end
        total++;
        if (!bs || ov) begin
            bad++;
            $display("FAIL basic_busy busy_seen=%0d overlap=%0d want 1/0", bs, ov);
        end
        e = sb.pop_front();
        total++;
        if ({quotient, remainder, div_by_zero} !== e) begin
            bad++;
            $display("FAIL basic_result got=%0d r%0d z%0d want=%0d r%0d z%0d",
                     quotient, remainder, div_by_zero, e.q, e.r, e.z);
        end
        repeat (3) @(negedge clk);
        total++;
        if ({quotient, remainder, div_by_zero} !== e || done !== 1'b0) begin
            bad++;
            $display("FAIL basic_hold got=%0d r%0d z%0d done=%0d want=%0d r%0d z%0d done=0",
                     quotient, remainder, div_by_zero, done, e.q, e.r, e.z);
        end
    endtask

    task automatic test_patterns();
        int pat[3][2] = '{'{200, 7}, '{255, 1}, '{7, 9}};
        int lat; bit bs, ov, to; exp_t e;
        for (int i = 0; i < 3; i++) begin
            sb.push_back(model(pat[i][0], pat[i][1]));
            drive_start(pat[i][0], pat[i][1]);
            wait_done(lat, bs, ov, to);
            e = sb.pop_front();
            total++;
            if (to || lat !== 8 || {quotient, remainder, div_by_zero} !== e) begin
                bad++;
                $display("FAIL pattern_%0d_%0d got=%0d r%0d z%0d lat=%0d want=%0d r%0d z%0d lat=8",
                         pat[i][0], pat[i][1], quotient, remainder, div_by_zero, lat, e.q, e.r, e.z);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_div_zero();
        int lat; bit bs, ov, to; exp_t e;
        sb.push_back(model(13, 0));
        drive_start(13, 0);
        wait_done(lat, bs, ov, to);
        total++;
        if (to || lat !== 0 || bs) begin
            bad++;
            $display("FAIL dz_timing got lat=%0d busy_seen=%0d want lat=0 busy_seen=0", lat, bs);
        end
        e = sb.pop_front();
        total++;
        if ({quotient, remainder, div_by_zero} !== e) begin
            bad++;
            $display("FAIL dz_result got=%0h r%0d z%0d want=%0h r%0d z%0d",
                     quotient, remainder, div_by_zero, e.q, e.r, e.z);
        end
        @(negedge clk);
        sb.push_back(model(100, 10));
        drive_start(100, 10);
        wait_done(lat, bs, ov, to);
        e = sb.pop_front();
        total++;
        if (to || {quotient, remainder, div_by_zero} !== e) begin
            bad++;
            $display("FAIL dz_recover got=%0d r%0d z%0d want=%0d r%0d z%0d",
                     quotient, remainder, div_by_zero, e.q, e.r, e.z);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int lat; bit bs, ov, to; exp_t e; bit seen;
        sb.push_back(model(200, 7));
        drive_start(200, 7);
        repeat (3) @(negedge clk);
        drive_start(50, 5);
        wait_done(lat, bs, ov, to);
        e = sb.pop_front();
        total++;
        if (to || {quotient, remainder, div_by_zero} !== e) begin
            bad++;
            $display("FAIL run_ignore got=%0d r%0d want=%0d r%0d", quotient, remainder, e.q, e.r);
        end
        @(negedge clk);
        sb.push_back(model(200, 7));
        drive_start(200, 7);
        wait_done(lat, bs, ov, to);
        e = sb.pop_front();
        total++;
        if (to || {quotient, remainder, div_by_zero} !== e) begin
            bad++;
            $display("FAIL b2b_first got=%0d r%0d want=%0d r%0d", quotient, remainder, e.q, e.r);
        end
        sb.push_back(model(50, 5));
        drive_start(50, 5);
        wait_done(lat, bs, ov, to);
        total++;
        if (to || lat + 1 !== 9) begin
            bad++;
            $display("FAIL b2b_gap got=%0d want=9", lat + 1);
        end
        e = sb.pop_front();
        total++;
        if ({quotient, remainder, div_by_zero} !== e) begin
            bad++;
            $display("FAIL b2b_second got=%0d r%0d want=%0d r%0d", quotient, remainder, e.q, e.r);
        end
        @(negedge clk);
        drive_start(100, 10);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1;
        end
        total++;
        if (seen || {busy, done, quotient, remainder, div_by_zero} !== '0) begin
            bad++;
            $display("FAIL run_reset done_seen=%0d outs=%b want 0/0", seen,
                     {busy, done, quotient, remainder, div_by_zero});
        end
        sb.push_back(model(200, 7));
        drive_start(200, 7);
        wait_done(lat, bs, ov, to);
        e = sb.pop_front();
        total++;
        if (to || lat !== 8 || {quotient, remainder, div_by_zero} !== e) begin
            bad++;
            $display("FAIL after_reset got=%0d r%0d lat=%0d want=%0d r%0d lat=8",
                     quotient, remainder, lat, e.q, e.r);
        end
        @(negedge clk);
    endtask

    task automatic test_sweep();
        int lat; bit bs, ov, to; exp_t e;
        for (int dd = 0; dd < 256; dd++) begin
            for (int dv = 1; dv < 16; dv++) begin
                sb.push_back(model(dd, dv));
                drive_start(dd, dv);
                wait_done(lat, bs, ov, to);
                e = sb.pop_front();
                total++;
                if (to || ov || {quotient, remainder, div_by_zero} !== e ||
                    int'(quotient) * dv + int'(remainder) != dd || int'(remainder) >= dv) begin
                    bad++;
                    $display("FAIL sweep_%0d_%0d got=%0d r%0d z%0d want=%0d r%0d z%0d",
                             dd, dv, quotient, remainder, div_by_zero, e.q, e.r, e.z);
                end
            end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        test_reset();
        test_basic();
        test_patterns();
        test_div_zero();
        test_back_to_back();
        test_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
